instr_decode_pipe: RTL and testbench

INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

---
 rtl/instr_decode_pipe_if.sv | 28 ++
 rtl/instr_decode_pipe.sv | 129 ++++++++++++
 tb/tb_instr_decode_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_pipe_if.sv
// rtl/instr_decode_pipe_if.sv - instruction in / decoded beat out handshake bundle
interface instr_decode_pipe_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [ADDR_W-1:0] out_adrs;
  logic [15:0]       out_data;
  logic              out_last;
  logic              out_err;
  logic              busy;

  // upstream/downstream environment view
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_adrs, out_data, out_last, out_err, busy
  );

  // decoder view
  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, out_opcode, out_adrs, out_data, out_last, out_err, busy
  );
endinterface

// File: rtl/instr_decode_pipe.sv
// rtl/instr_decode_pipe.sv - one-stage instruction decoder with matrix row burst expansion
module instr_decode_pipe #(
  parameter int         MAT_DIM  = 5,
  parameter int         NUM_MAT  = 4,
  parameter int         ADDR_W   = 8,
  parameter logic [3:0] BURST_OP = 4'h5
) (
  input  logic               clk,
  input  logic               rst,
  instr_decode_pipe_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [ADDR_W-1:0] DIM_A  = ADDR_W'(MAT_DIM);
  localparam logic [ADDR_W-1:0] MAT_SZ = ADDR_W'(MAT_DIM * MAT_DIM);
  localparam logic [2:0]        LAST_BEAT = 3'(MAT_DIM - 1);
  localparam logic [2:0]        PRE_LAST  = 3'(MAT_DIM - 2);

  state_t            state;
  logic [2:0]        beat;
  logic              out_valid_q;
  logic [3:0]        out_opcode_q;
  logic [ADDR_W-1:0] out_adrs_q;
  logic [15:0]       out_data_q;
  logic              out_last_q;
  logic              out_err_q;
  logic              busy_q;

  logic [3:0]        opcode;
  logic [2:0]        col;
  logic [2:0]        row;
  logic [1:0]        id;
  logic [15:0]       data_w;
  logic              legal;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] elem_adrs;
  logic              in_xfer;
  logic              out_xfer;

  assign opcode = bus.instr[3:0];
  assign col    = bus.instr[6:4];
  assign row    = bus.instr[9:7];
  assign id     = bus.instr[11:10];

  // high opcodes carry the location byte in the upper half of the payload
  assign data_w = opcode[3] ? {bus.instr[11:4], bus.instr[19:12]}
                            : {bus.instr[19:12], bus.instr[27:20]};

  assign legal = ({1'b0, col} < 4'(MAT_DIM)) &&
                 ({1'b0, row} < 4'(MAT_DIM)) &&
                 ({1'b0, id}  < 3'(NUM_MAT));

  // row base is shared by single beats and the first burst beat (col 0)
  assign row_base  = ADDR_W'(id) * MAT_SZ + ADDR_W'(row) * DIM_A;
  assign elem_adrs = row_base + ADDR_W'(col);

  // the output register may be refilled in the same cycle it drains
  assign bus.in_ready = !busy_q && (!out_valid_q || bus.out_ready);
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = out_valid_q && bus.out_ready;

  assign bus.out_valid  = out_valid_q;
  assign bus.out_opcode = out_opcode_q;
  assign bus.out_adrs   = out_adrs_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_err    = out_err_q;
  assign bus.busy       = busy_q;

  // decode stage and burst sequencer; outputs only change on accept or transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat         <= 3'd0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= 4'd0;
      out_adrs_q   <= '0;
      out_data_q   <= 16'd0;
      out_last_q   <= 1'b0;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            out_valid_q  <= 1'b1;
            out_opcode_q <= opcode;
            out_data_q   <= data_w;
            beat         <= 3'd0;
            if (!legal) begin
              out_adrs_q <= '0;
              out_last_q <= 1'b1;
              out_err_q  <= 1'b1;
            end else if (opcode == BURST_OP) begin
              state      <= BURST;
              busy_q     <= 1'b1;
              out_adrs_q <= row_base;
              out_last_q <= 1'b0;
              out_err_q  <= 1'b0;
            end else begin
              out_adrs_q <= elem_adrs;
              out_last_q <= 1'b1;
              out_err_q  <= 1'b0;
            end
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
          end
        end
        BURST: begin
          if (out_xfer) begin
            if (beat == LAST_BEAT) begin
              state       <= IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              beat        <= 3'd0;
            end else begin
              beat       <= beat + 3'd1;
              out_adrs_q <= out_adrs_q + ADDR_W'(1);
              out_last_q <= (beat == PRE_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// tb/tb_instr_decode_pipe.sv - directed self-checking bench for instr_decode_pipe
module tb_instr_decode_pipe;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  instr_decode_pipe_if #(.ADDR_W(8)) bus ();

  instr_decode_pipe #(
    .MAT_DIM (5),
    .NUM_MAT (4),
    .ADDR_W  (8),
    .BURST_OP(4'h5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, opcode, adrs, data, last, err, busy} packed into 32 bits
  function automatic logic [31:0] obs();
    return {bus.out_valid, bus.out_opcode, bus.out_adrs, bus.out_data,
            bus.out_last, bus.out_err, bus.busy};
  endfunction

  function automatic logic [31:0] beat_v(input logic v, input logic [3:0] op,
                                         input logic [7:0] a, input logic [15:0] d,
                                         input logic l, input logic e, input logic b);
    return {v, op, a, d, l, e, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    total++;
    if (obs() !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%08h exp=%08h", obs(), 32'd0);
    end
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    logic [31:0] e;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h0ABCD531;
    tick();
    bus.in_valid = 1'b0;
    e = beat_v(1'b1, 4'h1, 8'd38, 16'hCDAB, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL single_beat got=%08h exp=%08h", obs(), e);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_burst();
    logic [31:0] e;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h0AB12205;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e = beat_v(1'b1, 4'h5, 8'(20 + k), 16'h12AB, (k == 4), 1'b0, 1'b1);
      total++;
      if (obs() !== e || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL burst_beat%0d got=%08h/rdy%b exp=%08h/rdy0", k, obs(), bus.in_ready, e);
      end
      if (k == 2) begin
        bus.out_ready = 1'b0;
        tick();
        total++;
        if (obs() !== e) begin
          bad++;
          $display("FAIL burst_stall got=%08h exp=%08h", obs(), e);
        end
        bus.out_ready = 1'b1;
        #1;
      end
      tick();
    end
    total++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL burst_end got=busy%b/val%b/rdy%b exp=busy0/val0/rdy1",
               bus.busy, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] e;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h00000281;
    tick();
    bus.in_valid = 1'b0;
    e = beat_v(1'b1, 4'h1, 8'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL illegal_row got=%08h exp=%08h", obs(), e);
    end
    // illegal location with the burst opcode must not start a burst
    bus.in_valid = 1'b1;
    bus.instr    = 32'h00000C75;
    tick();
    bus.in_valid = 1'b0;
    e = beat_v(1'b1, 4'h5, 8'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL illegal_burst got=%08h exp=%08h", obs(), e);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] ea;
    logic [31:0] eb;
    ea = beat_v(1'b1, 4'h1, 8'd38, 16'hCDAB, 1'b1, 1'b0, 1'b0);
    eb = beat_v(1'b1, 4'h9, 8'd12, 16'h1234, 1'b1, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h0ABCD531;
    tick();
    bus.out_ready = 1'b0;
    bus.instr     = 32'h00034129;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs() !== ea || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got=%08h/rdy%b exp=%08h/rdy0", k, obs(), bus.in_ready, ea);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got=%b exp=1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (obs() !== eb) begin
      bad++;
      $display("FAIL stall_next got=%08h exp=%08h", obs(), eb);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_no_dup got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [31:0] exp_b [4];
    ins[0] = 32'h0ABCD531;
    ins[1] = 32'h00034129;
    ins[2] = 32'h00000C00;
    ins[3] = 32'h00000071;
    exp_b[0] = beat_v(1'b1, 4'h1, 8'd38, 16'hCDAB, 1'b1, 1'b0, 1'b0);
    exp_b[1] = beat_v(1'b1, 4'h9, 8'd12, 16'h1234, 1'b1, 1'b0, 1'b0);
    exp_b[2] = beat_v(1'b1, 4'h0, 8'd75, 16'h0000, 1'b1, 1'b0, 1'b0);
    exp_b[3] = beat_v(1'b1, 4'h1, 8'd0,  16'h0000, 1'b1, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.instr    = ins[k];
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready%0d got=%b exp=1", k, bus.in_ready);
      end
      tick();
      total++;
      if (obs() !== exp_b[k]) begin
        bad++;
        $display("FAIL b2b_beat%0d got=%08h exp=%08h", k, obs(), exp_b[k]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_burst();
    logic [31:0] e;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h00000205;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    e = beat_v(1'b1, 4'h5, 8'd22, 16'h0000, 1'b0, 1'b0, 1'b1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL abort_pre got=%08h exp=%08h", obs(), e);
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs() !== 32'd0) begin
      bad++;
      $display("FAIL abort_async got=%08h exp=%08h", obs(), 32'd0);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_after got=rdy%b/val%b exp=rdy1/val0", bus.in_ready, bus.out_valid);
    end
    bus.in_valid = 1'b1;
    bus.instr    = 32'h0ABCD531;
    tick();
    bus.in_valid = 1'b0;
    e = beat_v(1'b1, 4'h1, 8'd38, 16'hCDAB, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL abort_resume got=%08h exp=%08h", obs(), e);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_residue got=val%b/busy%b exp=val0/busy0", bus.out_valid, bus.busy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_burst();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_rst_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
